// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-source result queues with round-robin common data bus broadcast

// One result queue: DEPTH entries of W bits, pointer-wrapped, cleared by reset or flush.
module cdb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage is not reset; only the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; push and pop together keep count.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Top: queues per functional unit, round-robin grant from start-of-cycle occupancy.
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data
);
    localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int ENT_W = TAG_W + DATA_W;

    logic [NUM_SRC-1:0] q_full;
    logic [NUM_SRC-1:0] q_empty;
    logic [NUM_SRC-1:0] q_push;
    logic [NUM_SRC-1:0] q_pop;
    logic [ENT_W-1:0]   q_head [NUM_SRC];

    logic [RR_W-1:0]    rr_ptr;
    logic [RR_W-1:0]    grant_idx;
    logic               grant_valid;
    logic [RR_W-1:0]    rr_next;
    logic [ENT_W-1:0]   grant_ent;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        // Ready looks only at queue occupancy (and reset), so a full queue never accepts even when popped.
        assign src_ready[i] = !rst && !q_full[i];
        assign q_push[i]    = src_valid[i] && src_ready[i] && !flush;
        assign q_pop[i]     = grant_valid && (grant_idx == RR_W'(i)) && !flush && !rst;

        cdb_result_fifo #(
            .DEPTH (DEPTH),
            .W     (ENT_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (q_push[i]),
            .wdata ({src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]}),
            .pop   (q_pop[i]),
            .rdata (q_head[i]),
            .full  (q_full[i]),
            .empty (q_empty[i])
        );
    end

    // Round-robin scan from rr_ptr over queues that were non-empty before this edge.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!grant_valid && !q_empty[(int'(rr_ptr) + k) % NUM_SRC]) begin
                grant_valid = 1'b1;
                grant_idx   = RR_W'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
        rr_next   = RR_W'((int'(grant_idx) + 1) % NUM_SRC);
        grant_ent = q_head[grant_idx];
    end

    // Registered broadcast: a granted head leaves the queue and drives the bus for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (grant_valid) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= grant_ent[ENT_W-1:DATA_W];
            cdb_data  <= grant_ent[DATA_W-1:0];
            rr_ptr    <= rr_next;
        end else begin
            cdb_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed checks of cdb_arbiter against a queue model
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int D  = 2;
    localparam int TW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N*TW-1:0] src_tag = '0;
    logic [N*DW-1:0] src_data = '0;
    logic [N-1:0]    src_ready;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [TW+DW-1:0] mq [N][$];
    int               m_rr = 0;
    logic             m_valid = 1'b0;
    logic [TW-1:0]    m_tag = '0;
    logic [DW-1:0]    m_data = '0;

    cdb_arbiter #(.NUM_SRC(N), .DEPTH(D), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (src_valid),
        .src_tag   (src_tag),
        .src_data  (src_data),
        .src_ready (src_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic drive(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        src_valid[i]          = 1'b1;
        src_tag[i*TW +: TW]   = t;
        src_data[i*DW +: DW]  = d;
    endtask

    // One clock: apply the model's view of the edge, then compare outputs on the falling edge.
    task automatic cycle();
        bit [N-1:0] pre_ready;
        bit [N-1:0] exp_ready;
        bit found;
        @(posedge clk);
        for (int i = 0; i < N; i++) pre_ready[i] = !rst && (mq[i].size() < D);
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_valid = 1'b0;
        end else begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int s;
                s = (m_rr + k) % N;
                if (!found && mq[s].size() > 0) begin
                    logic [TW+DW-1:0] e;
                    found = 1'b1;
                    e = mq[s].pop_front();
                    m_tag = e[TW+DW-1:DW];
                    m_data = e[DW-1:0];
                    m_rr = (s + 1) % N;
                end
            end
            m_valid = found;
            for (int i = 0; i < N; i++)
                if (src_valid[i] && pre_ready[i])
                    mq[i].push_back({src_tag[i*TW +: TW], src_data[i*DW +: DW]});
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) exp_ready[i] = !rst && (mq[i].size() < D);
        check("src_ready", 64'(src_ready), 64'(exp_ready));
        check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        if (m_valid) begin
            check("cdb_tag", 64'(cdb_tag), 64'(m_tag));
            check("cdb_data", 64'(cdb_data), 64'(m_data));
        end
    endtask

    task automatic idle();
        src_valid = '0; flush = 1'b0; rst = 1'b0;
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        cycle(); cycle();
        check("rst_ready", 64'(src_ready), 64'h0);
        check("rst_tag", 64'(cdb_tag), 64'h0);
        check("rst_data", 64'(cdb_data), 64'h0);
        idle();
        cycle();
        check("post_rst_ready", 64'(src_ready), 64'hF);

        // single push on src1, broadcast exactly one cycle later
        drive(1, 5'h0A, 32'hDEADBEEF);
        cycle();
        check("s1_not_yet", 64'(cdb_valid), 64'h0);
        idle();
        cycle();
        check("s1_valid", 64'(cdb_valid), 64'h1);
        check("s1_tag", 64'(cdb_tag), 64'h0A);
        check("s1_data", 64'(cdb_data), 64'hDEADBEEF);
        cycle();
        check("s1_done", 64'(cdb_valid), 64'h0);

        // all four push at once from rr_ptr=0
        rst = 1'b1; cycle(); idle();
        for (int i = 0; i < N; i++) drive(i, TW'(i + 1), DW'(32'h100 + i));
        cycle();
        idle();
        for (int i = 0; i < N; i++) begin
            cycle();
            check("s4_tag", 64'(cdb_tag), 64'(i + 1));
        end
        cycle();
        check("s4_idle", 64'(cdb_valid), 64'h0);

        // src2 back-to-back, then src0/src3 continuously valid
        for (int j = 0; j < 3; j++) begin drive(2, TW'(j + 8), DW'(j)); cycle(); end
        idle();
        for (int j = 0; j < 10; j++) begin
            drive(0, TW'(j), DW'(j)); drive(3, TW'(j + 16), DW'(j + 16)); cycle();
        end
        idle(); cycle(); cycle(); cycle();

        // fill src0/src1 then flush
        drive(0, 5'h11, 32'h1); drive(1, 5'h12, 32'h2); cycle();
        drive(0, 5'h13, 32'h3); drive(1, 5'h14, 32'h4); cycle();
        flush = 1'b1; cycle();
        check("flush_valid", 64'(cdb_valid), 64'h0);
        check("flush_ready", 64'(src_ready), 64'hF);
        idle(); cycle(); cycle();

        // reset with queues occupied
        drive(0, 5'h1E, 32'h5); drive(2, 5'h1F, 32'h6); cycle();
        rst = 1'b1; cycle();
        check("mid_rst_valid", 64'(cdb_valid), 64'h0);
        idle(); cycle();
        check("mid_rst_stale", 64'(cdb_valid), 64'h0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < N; i++) begin
                src_valid[i]         = ($urandom_range(0, 99) < 45);
                src_tag[i*TW +: TW]  = TW'($urandom);
                src_data[i*DW +: DW] = $urandom;
            end
            cycle();
        end
        idle(); cycle(); cycle(); cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
